// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shifter family: FSM state encoding and default width.
package shift_normalizer_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_normalizer_stage.sv
// One conditional power-of-two normalization step: shifts by 2^k when the
// bits that would be shifted out are all zero.
module norm_stage #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [CW-1:0]    k,
  input  logic             left,
  output logic [WIDTH-1:0] shifted,
  output logic             taken
);

  localparam logic [CW-1:0]    ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [CW-1:0]    amt_s;
  logic [WIDTH-1:0] mask_s;

  // Select the 2^k bits on the side being normalized and shift when they are clear
  always_comb begin
    amt_s   = ONE << k;
    mask_s  = ZERO;
    shifted = value;
    if (left) begin
      mask_s = ~(ONES >> amt_s);
    end else begin
      mask_s = ~(ONES << amt_s);
    end
    taken = ((value & mask_s) == ZERO);
    if (taken) begin
      if (left) begin
        shifted = value << amt_s;
      end else begin
        shifted = value >> amt_s;
      end
    end else begin
      shifted = value;
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle leading/trailing-zero normalizer: binary search over stages
// CW-1..0, one stage per cycle, with a valid/ready handshake on each side.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_left,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam logic [CW-1:0]    ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    K_TOP = CW'(CW - 1);
  localparam logic [CW-1:0]    CZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};

  state_e           state_r;
  logic [WIDTH-1:0] work_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    k_r;
  logic             left_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             zero_r;

  logic [WIDTH-1:0] stage_value_s;
  logic             taken_s;
  logic [CW-1:0]    amt_s;

  norm_stage #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_stage (
    .value   (work_r),
    .k       (k_r),
    .left    (left_r),
    .shifted (stage_value_s),
    .taken   (taken_s)
  );

  assign amt_s = ONE << k_r;

  // FSM, working value, shift count and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      work_r      <= ZERO;
      count_r     <= CZERO;
      k_r         <= CZERO;
      left_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            work_r     <= in_data;
            left_r     <= in_left;
            count_r    <= CZERO;
            k_r        <= K_TOP;
            zero_r     <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          work_r <= stage_value_s;
          // Partial sums of distinct powers below WIDTH never exceed WIDTH-1
          if (taken_s) begin
            count_r <= count_r + amt_s;
          end
          if (k_r == CZERO) begin
            zero_r      <= (stage_value_s == ZERO);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            k_r <= k_r - ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          work_r      <= ZERO;
          count_r     <= CZERO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          zero_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = work_r;
  assign out_count = count_r;
  assign out_zero  = zero_r;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed plus random checks of shift_normalizer against a simple
// bit-scanning reference model (WIDTH=32).
module tb_shift_normalizer;

  localparam int WIDTH = 32;
  localparam int CW    = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_left;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
  logic             out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  shift_normalizer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_left   (in_left),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan for the first one bit from the chosen end
  function automatic void model(input logic [WIDTH-1:0] d, input logic l,
                                output logic [WIDTH-1:0] od, output int oc, output logic oz);
    int n;
    if (d == 32'd0) begin
      od = 32'd0;
      oc = WIDTH - 1;
      oz = 1'b1;
    end else begin
      n = 0;
      if (l) begin
        while (d[WIDTH-1-n] == 1'b0) n++;
        od = d << n;
      end else begin
        while (d[n] == 1'b0) n++;
        od = d >> n;
      end
      oc = n;
      oz = 1'b0;
    end
  endfunction

  task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input logic l, input int hold);
    logic [WIDTH-1:0] exp_d;
    int               exp_c;
    logic             exp_z;
    int               lat;
    model(d, l, exp_d, exp_c, exp_z);
    check({tag, ".ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_left  = l;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, lat, CW);
    check({tag, ".data"}, out_data, exp_d);
    check({tag, ".count"}, out_count, exp_c);
    check({tag, ".zero"}, out_zero, exp_z);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_left  = ~l;
      step();
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_ready"}, in_ready, 0);
      check({tag, ".hold_data"}, out_data, exp_d);
      check({tag, ".hold_count"}, out_count, exp_c);
      check({tag, ".hold_zero"}, out_zero, exp_z);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".exit_valid"}, out_valid, 0);
    check({tag, ".exit_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_left   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.out_count", out_count, 0);
    check("rst.out_zero", out_zero, 0);
    rst_n = 1'b1;
    step();

    run_op("lz2", 32'd2, 1'b1, 0);
    run_op("tz24", 32'd24, 1'b0, 0);
    run_op("zero_l", 32'd0, 1'b1, 0);
    run_op("zero_r", 32'd0, 1'b0, 0);
    run_op("msb_set", 32'h8000_0000, 1'b1, 0);
    run_op("lsb_set", 32'd7, 1'b0, 0);
    run_op("bp", 32'h0001_2340, 1'b0, 3);

    // Reset during the third shift cycle
    in_valid = 1'b1;
    in_data  = 32'h0012_3456;
    in_left  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst.in_ready", in_ready, 1);
    check("midrst.out_valid", out_valid, 0);
    check("midrst.out_data", out_data, 0);
    check("midrst.out_count", out_count, 0);
    check("midrst.out_zero", out_zero, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("midrst.no_output", out_valid, 0);
    end
    run_op("after_rst", 32'd5, 1'b1, 0);
    check("after_rst.data_lit", out_data, 32'hA000_0000);

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d = d >> $urandom_range(0, 31);
      else d = d << $urandom_range(0, 31);
      run_op("rand", d, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
